// File: rtl/day5_3x8_decoder.sv
// Registered N-to-2**N one-hot/one-cold decoder with enable and sync reset.
// Define DECODER_HOLD_EN to make en=0 hold bus/valid/idx (sticky select).
module day5_3x8_decoder #(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W-1:0]  state,
    output logic [OUT_W-1:0] bus,
    output logic             valid,
    output logic [IN_W-1:0]  idx
);

    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{POL}};

    if (OUT_W != (2 ** IN_W)) begin : g_bad_width
        $error("day5_3x8_decoder: OUT_W must equal 2**IN_W");
    end

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] decoded;

    always_comb begin
        onehot = '0;
        onehot[state] = 1'b1;
        // Polarity applied by XOR so one-cold falls out of the same decode
        decoded = onehot ^ INACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus   <= INACTIVE;
            valid <= 1'b0;
            idx   <= '0;
        end else if (en) begin
            bus   <= decoded;
            valid <= 1'b1;
            idx   <= state;
        end else begin
`ifdef DECODER_HOLD_EN
            bus   <= bus;
            valid <= valid;
            idx   <= idx;
`else
            bus   <= INACTIVE;
            valid <= 1'b0;
            idx   <= idx;
`endif
        end
    end

endmodule

// File: tb/tb_day5_3x8_decoder.sv
// Self-checking bench: active-high and active-low decoders against a
// behavioural model of valid/idx, from which the expected bus is derived.
module tb_day5_3x8_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [2:0] state = 3'd0;

    logic [7:0] bus_h, bus_l;
    logic       valid_h, valid_l;
    logic [2:0] idx_h, idx_l;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    day5_3x8_decoder #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .reset(reset), .en(en), .state(state),
        .bus(bus_h), .valid(valid_h), .idx(idx_h)
    );

    day5_3x8_decoder #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .reset(reset), .en(en), .state(state),
        .bus(bus_l), .valid(valid_l), .idx(idx_l)
    );

    // Model: what was last selected, and whether the selection is live.
    bit m_known = 1'b0;
    bit m_valid = 1'b0;
    int m_idx = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_known <= 1'b1;
        end else if (en) begin
            m_valid <= 1'b1;
            m_idx   <= int'(state);
        end else begin
`ifndef DECODER_HOLD_EN
            m_valid <= 1'b0;
`endif
        end
    end

    function automatic logic [7:0] model_bus(bit v, int i, bit low);
        logic [7:0] b;
        b = v ? 8'(2 ** i) : 8'h00;
        return low ? ~b : b;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("bus_h", 32'(bus_h), 32'(model_bus(m_valid, m_idx, 1'b0)));
            chk("valid_h", 32'(valid_h), 32'(m_valid));
            chk("idx_h", 32'(idx_h), 32'(m_idx));
            chk("onehot_h", $countones(bus_h), m_valid ? 1 : 0);
            chk("bus_l", 32'(bus_l), 32'(model_bus(m_valid, m_idx, 1'b1)));
            chk("valid_l", 32'(valid_l), 32'(m_valid));
            chk("idx_l", 32'(idx_l), 32'(m_idx));
        end
    end

    task automatic step(bit r, bit e, logic [2:0] s);
        reset = r;
        en    = e;
        state = s;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                  8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        #1;
        step(1'b1, 1'b1, 3'd0);
        step(1'b1, 1'b1, 3'd0);
        chk("rst_bus", 32'(bus_h), 32'h00);
        chk("rst_valid", 32'(valid_h), 32'h0);
        chk("rst_idx", 32'(idx_h), 32'h0);
        chk("rst_bus_l", 32'(bus_l), 32'hFF);

        step(1'b0, 1'b1, 3'd0);
        chk("first_bus", 32'(bus_h), 32'h01);
        chk("first_valid", 32'(valid_h), 32'h1);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i));
            chk("sweep_bus", 32'(bus_h), 32'(sweep_exp[i]));
            chk("sweep_idx", 32'(idx_h), 32'(i));
        end

        step(1'b0, 1'b1, 3'd5);
        chk("sel5_bus", 32'(bus_h), 32'h20);
        step(1'b0, 1'b0, 3'd1);
`ifdef DECODER_HOLD_EN
        chk("hold_bus", 32'(bus_h), 32'h20);
        chk("hold_valid", 32'(valid_h), 32'h1);
`else
        chk("idle_bus", 32'(bus_h), 32'h00);
        chk("idle_valid", 32'(valid_h), 32'h0);
`endif
        chk("idle_idx", 32'(idx_h), 32'h5);

        for (int i = 0; i < 25; i++)
            step(1'b0, 1'b1, 3'($urandom_range(0, 7)));

        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)));

        step(1'b0, 1'b1, 3'd3);
        step(1'b1, 1'b1, 3'd7);
        chk("midrst_bus", 32'(bus_h), 32'h00);
        chk("midrst_valid", 32'(valid_h), 32'h0);
        step(1'b0, 1'b1, 3'd7);
        chk("post_rst_bus", 32'(bus_h), 32'h80);

        step(1'b0, 1'b1, 3'd2);
        chk("low_bus", 32'(bus_l), 32'hFB);
        chk("low_valid", 32'(valid_l), 32'h1);
        step(1'b1, 1'b1, 3'd2);
        chk("low_rst_bus", 32'(bus_l), 32'hFF);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/day5_3x8_decoder.md
Name: day5_3x8_decoder

Overview:
- Registered 3-to-8 one-hot decoder: converts a 3-bit `state` code into an 8-bit `bus` with exactly one active line.
- Used as a select/strobe generator driven by a small FSM state register.
- Outputs are registered, with synchronous enable and synchronous active-high reset.
- Width and output polarity are parameterized; defaults give the classic 3x8 decoder.

Parameters:
- IN_W, 3, width of the `state` code.
- OUT_W, 8, width of `bus`; must equal 2**IN_W. Elaboration error (generate-time $error) if not.
- ACTIVE_LOW, 0, 0 = selected line is 1 and others 0; 1 = selected line is 0 and others 1.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  decode enable; tie high for plain decoder use.
- state  input  IN_W  binary code to decode.
- bus  output  OUT_W  registered one-hot (or one-cold when ACTIVE_LOW=1) decode of `state`.
- valid  output  1  registered; 1 when `bus` holds a decode of a sampled `state`.
- idx  output  IN_W  registered copy of the last decoded `state`.

Behaviour:
- The Already-decided requirement is: one clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
- Reset (`reset`=1 at a clk edge) has priority over everything:
  - `bus` <= all-inactive (all 0s for ACTIVE_LOW=0, all 1s for ACTIVE_LOW=1).
  - `valid` <= 0.
  - `idx` <= 0.
- Normal decode (`reset`=0, `en`=1 at a clk edge):
  - `bus[state]` <= active level; every other bit <= inactive level.
  - `valid` <= 1.
  - `idx` <= `state`.
- Idle (`reset`=0, `en`=0): `bus` <= all-inactive, `valid` <= 0, `idx` holds its value (default build; see Optional Feature).
- Latency: exactly 1 clock from sampled `state`/`en` to `bus`/`valid`/`idx`.
  - A new code every cycle gives a new one-hot every cycle; no bubbles.
- Invariant: whenever `valid`=1, `bus` has exactly one active bit, at position `idx`. Whenever `valid`=0, no bit is active.
- All 2**IN_W codes are legal, including boundaries 0 (bus bit 0) and 2**IN_W-1 (bus MSB). There are no out-of-range codes.
- Reset asserted mid-stream clears outputs on that edge. The first decode after deassert appears one cycle after the first edge with `reset`=0 and `en`=1.
- X/Z on `state` is not filtered; the RTL must not add latches.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DECODER_HOLD_EN
- Defined: when `en`=0 (no reset), `bus`, `valid` and `idx` all hold their previous values, giving a sticky select.
- Undefined: `en`=0 clears `bus` to all-inactive and `valid` to 0; `idx` holds.
- Reset behaviour is identical in both builds.

Test Plan:
- Reset then release with `en`=1, `state`=3'b000 -> after reset: bus=8'h00, valid=0, idx=0; next edge: bus=8'h01, valid=1, idx=0.
- Sweep `state` 0..7 one per cycle with `en`=1 -> bus = 01,02,04,08,10,20,40,80 each one cycle later; `valid` stays 1; `idx` tracks.
- 25 random `state` values (uniform in 0..7), 10-time-unit spacing, `en`=1 -> every cycle: bus == 1<<idx, popcount(bus)==1, idx equals `state` from the prior edge.
- `state`=3'b101 decoded (bus=8'h20), then `en`=0 -> default build: bus=8'h00, valid=0, idx=5. With DECODER_HOLD_EN: bus=8'h20, valid=1, idx=5.
- `reset`=1 while `state`=3'b111, `en`=1 -> bus=8'h00, valid=0 on that edge. Deassert -> bus=8'h80 one edge later.
- ACTIVE_LOW=1, `state`=3'b010 -> bus=8'hFB, valid=1. Reset -> bus=8'hFF.
